// File: rtl/fpall_pkg.sv
// fpall_pkg: shared FP-unit types, FP32 bias constant and the rounding-increment decision.
//   fp_fmt_e      operand format selector (only FP32 is handled by fp32_to_int)
//   round_mode_e  RNE, RTZ, RDN, RUP, RMM
//   roundUp()     1 when the truncated magnitude must be incremented
package fpall_pkg;
  typedef enum logic [1:0] {FP32 = 2'd0, FP64 = 2'd1, FP16 = 2'd2, BF16 = 2'd3} fp_fmt_e;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} round_mode_e;
  localparam logic [7:0] FP32_BIAS = 8'd127;
  function automatic logic roundUp(input round_mode_e rm, input logic sign, input logic lsb,
                                   input logic rnd, input logic stk);
    return rm == RNE ? rnd & (stk | lsb) :
           rm == RMM ? rnd :
           rm == RUP ? (rnd | stk) & ~sign :
           rm == RDN ? (rnd | stk) & sign : 1'b0;
  endfunction
endpackage

// File: rtl/rshift_sticky_32.sv
// rshift_sticky_32: 32-bit right barrel shifter reporting the last bit shifted out and the OR of the rest.
//   din   in  32  value to shift
//   amt   in  5   shift amount
//   dout  out 32  din >> amt
//   rnd   out 1   bit din[amt-1] (0 when amt = 0)
//   stk   out 1   OR of din[amt-2:0]
module rshift_sticky_32 (
  input  logic [31:0] din,
  input  logic [4:0]  amt,
  output logic [31:0] dout,
  output logic        rnd,
  output logic        stk
);
  logic [63:0] ext;
  // Shifting into a 64-bit window keeps the discarded bits in the low half.
  assign ext  = {din, 32'd0} >> amt;
  assign dout = ext[63:32];
  assign rnd  = ext[31];
  assign stk  = |ext[30:0];
endmodule

// File: rtl/fp32_to_int.sv
// fp32_to_int: 3-stage binary32 to int32/uint32 converter with rounding modes and invalid/inexact flags.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (X, fmt, rm, is_signed travel together)
//   out_valid / out_ready result handshake
//   R, invalid, inexact   integer result and flags
module fp32_to_int
  import fpall_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  fp_fmt_e     fmt,
  input  logic [31:0] X,
  input  round_mode_e rm,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] R,
  output logic        invalid,
  output logic        inexact
);
  logic v1, v2, v3, adv2, adv3;
  logic s1Sign, s1Signed, s1FmtOk, s1Nan, s1Ovf;
  logic [7:0] s1Exp;
  logic [22:0] s1Frac;
  round_mode_e s1Rm;
  logic s2Sign, s2Signed, s2FmtOk, s2Nan, s2Ovf, s2Rnd, s2Stk;
  logic [31:0] s2Mag;
  round_mode_e s2Rm;
  logic [31:0] shOut, d2Mag, negR, satR, d3R;
  logic shRnd, shStk, inRange, isHalf, d2Rnd, d2Stk;
  logic inc, sOvf, uOvf, bad, d3Inx;
  logic [32:0] mag33;
  logic [4:0] shAmt;
  assign adv3      = out_ready | ~v3;
  assign adv2      = ~v2 | adv3;
  assign in_ready  = ~v1 | adv2;
  assign out_valid = v3;
  // Stage 2: place the significand so bit 31 has weight 2^E, shift down by 31-E.
  assign shAmt   = 5'(FP32_BIAS + 8'd31 - s1Exp);
  assign inRange = s1Exp >= FP32_BIAS;
  assign isHalf  = s1Exp == FP32_BIAS - 8'd1;
  rshift_sticky_32 uShift (
    .din  ({1'b1, s1Frac, 8'd0}),
    .amt  (shAmt),
    .dout (shOut),
    .rnd  (shRnd),
    .stk  (shStk)
  );
  assign d2Mag = inRange ? shOut : 32'd0;
  assign d2Rnd = inRange ? shRnd : isHalf;
  assign d2Stk = inRange ? shStk : isHalf ? |s1Frac : (|s1Exp) | (|s1Frac);
  // Stage 3: round on 33 bits so a carry out of an all-ones uint32 is still seen as overflow.
  assign inc   = roundUp(s2Rm, s2Sign, s2Mag[0], s2Rnd, s2Stk);
  assign mag33 = {1'b0, s2Mag} + 33'(inc);
  assign negR  = ~mag33[31:0] + 32'd1;
  assign sOvf  = s2Sign ? mag33 > 33'h080000000 : mag33 > 33'h07FFFFFFF;
  assign uOvf  = s2Sign ? |mag33 : mag33[32];
  assign bad   = ~s2FmtOk | s2Nan | s2Ovf | (s2Signed ? sOvf : uOvf);
  assign satR  = ~s2FmtOk ? 32'd0 :
                 s2Nan    ? (s2Signed ? 32'h7FFFFFFF : 32'hFFFFFFFF) :
                 s2Signed ? (s2Sign ? 32'h80000000 : 32'h7FFFFFFF) :
                            (s2Sign ? 32'd0 : 32'hFFFFFFFF);
  // A negative operand that rounds to zero is a legal unsigned 0.
  assign d3R   = bad ? satR : s2Sign ? (s2Signed ? negR : 32'd0) : mag33[31:0];
  assign d3Inx = (s2Rnd | s2Stk) & ~bad;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      s1Sign <= 1'b0;
      s1Exp <= 8'd0;
      s1Frac <= 23'd0;
      s1Rm <= RNE;
      s1Signed <= 1'b0;
      s1FmtOk <= 1'b0;
      s1Nan <= 1'b0;
      s1Ovf <= 1'b0;
      s2Sign <= 1'b0;
      s2Mag <= 32'd0;
      s2Rnd <= 1'b0;
      s2Stk <= 1'b0;
      s2Rm <= RNE;
      s2Signed <= 1'b0;
      s2FmtOk <= 1'b0;
      s2Nan <= 1'b0;
      s2Ovf <= 1'b0;
      R <= 32'd0;
      invalid <= 1'b0;
      inexact <= 1'b0;
    end else begin
      if (in_ready) begin
        v1 <= in_valid;
        s1Sign <= X[31];
        s1Exp <= X[30:23];
        s1Frac <= X[22:0];
        s1Rm <= rm;
        s1Signed <= is_signed;
        s1FmtOk <= fmt == FP32;
        s1Nan <= (&X[30:23]) & (|X[22:0]);
        s1Ovf <= X[30:23] >= FP32_BIAS + 8'd32;
      end
      if (adv2) begin
        v2 <= v1;
        s2Sign <= s1Sign;
        s2Mag <= d2Mag;
        s2Rnd <= d2Rnd;
        s2Stk <= d2Stk;
        s2Rm <= s1Rm;
        s2Signed <= s1Signed;
        s2FmtOk <= s1FmtOk;
        s2Nan <= s1Nan;
        s2Ovf <= s1Ovf;
      end
      if (adv3) begin
        v3 <= v2;
        R <= d3R;
        invalid <= bad;
        inexact <= d3Inx;
      end
    end
  end
endmodule
